// File: rtl/sample_pwm_dac.sv
// Sample FIFO feeding a tick-aligned PWM DAC; one sample is popped per
// sample_tick and rendered as a 2^WIDTH-cycle PWM period.
module sample_pwm_dac #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     sample_tick,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     underrun_clr,
  output logic                     pwm_out,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   duty;
  logic [WIDTH-1:0]   pwm_cnt;
  logic               push, pop, underrun_set;

  assign sample_ready = (count < CNT_W'(DEPTH));
  assign push         = sample_valid && sample_ready;
  assign pop          = sample_tick && (count != '0);
  assign underrun_set = (state == RUN) && sample_tick && (count == '0);
  assign fifo_count   = count;
  assign pwm_out      = (state == RUN) && (pwm_cnt < duty);

  // Sample storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Duty register: reloads on pop, otherwise the last sample repeats
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)    duty <= '0;
    else if (pop) duty <= mem[rd_ptr];
  end

  // Period counter realigned to every tick, free-running otherwise
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)            pwm_cnt <= '0;
    else if (sample_tick) pwm_cnt <= '0;
    else                  pwm_cnt <= pwm_cnt + WIDTH'(1);
  end

  // Sticky underrun; a simultaneous set beats the clear
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)             underrun <= 1'b0;
    else if (underrun_set) underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  // IDLE waits for the first sample; RUN is left only through reset
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sample_pwm_dac.sv
// Scoreboard bench for sample_pwm_dac: accepted samples are queued and
// compared against measured PWM high time per tick-aligned period.
module tb_sample_pwm_dac;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PERIOD = 1 << WIDTH;

  logic                   clk = 1'b0;
  logic                   nrst = 1'b0;
  logic                   sample_tick = 1'b0;
  logic [WIDTH-1:0]       sample_in = '0;
  logic                   sample_valid = 1'b0;
  logic                   sample_ready;
  logic                   underrun_clr = 1'b0;
  logic                   pwm_out;
  logic                   underrun;
  logic [$clog2(DEPTH):0] fifo_count;

  sample_pwm_dac #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .sample_tick  (sample_tick),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun_clr (underrun_clr),
    .pwm_out      (pwm_out),
    .underrun     (underrun),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int q[$];
  int m_duty = 0;
  bit m_run = 1'b0;
  bit m_underrun = 1'b0;
  bit acc_pend = 1'b0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_duty = 0;
    m_run = 1'b0;
    m_underrun = 1'b0;
    acc_pend = 1'b0;
  endtask

  // Handshake monitor run at each falling edge while valid is held
  task automatic hs_step();
    if (acc_pend) begin
      sample_valid = 1'b0;
      acc_pend = 1'b0;
    end else if (sample_valid && sample_ready) begin
      q.push_back(int'(sample_in));
      acc_pend = 1'b1;
    end
  endtask

  task automatic push(input int v);
    bit done;
    done = 1'b0;
    sample_in = WIDTH'(v);
    sample_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (sample_ready) begin
        q.push_back(v);
        @(negedge clk);
        sample_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      check("push_timeout", 0, 1);
      sample_valid = 1'b0;
    end
  endtask

  // Drives one tick and measures the following 2^WIDTH-cycle period
  task automatic run_period(input bit clr);
    int hi;
    sample_tick = 1'b1;
    underrun_clr = clr;
    if (q.size() > 0) begin
      m_duty = q.pop_front();
      m_run = 1'b1;
    end else if (m_run) begin
      m_underrun = 1'b1;
    end
    if (clr && !(m_run && q.size() == 0 && m_underrun && !clr)) begin
      if (!(m_run && m_underrun)) m_underrun = 1'b0;
    end
    hs_step();
    hi = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin
      @(negedge clk);
      if (i == 0) begin
        sample_tick = 1'b0;
        underrun_clr = 1'b0;
        check("first_hi", int'(pwm_out), int'(m_run && m_duty != 0));
        check("fifo_count", int'(fifo_count), q.size());
        check("underrun", int'(underrun), int'(m_underrun));
      end
      hi += int'(pwm_out);
      hs_step();
    end
    check("high_cycles", hi, m_run ? m_duty : 0);
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    sample_tick = 1'b1;
    sample_valid = 1'b1;
    sample_in = 8'h55;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_count", int'(fifo_count), 0);
    nrst = 1'b1;
    sample_tick = 1'b0;
    sample_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_ready", int'(sample_ready), 1);
  endtask

  initial begin
    // 1: reset with activity on inputs
    @(negedge clk);
    apply_reset();

    // 2: three samples, one per period
    push(8'h40);
    push(8'h80);
    push(8'hFF);
    check("count_3", int'(fifo_count), 3);
    run_period(1'b0);
    run_period(1'b0);
    run_period(1'b0);

    // 3: fill the FIFO and hold a fifth sample until the next pop
    for (int v = 8'h10; v <= 8'h13; v++) push(v);
    sample_in = 8'h14;
    sample_valid = 1'b1;
    check("full_ready", int'(sample_ready), 0);
    check("full_count", int'(fifo_count), 4);
    for (int k = 0; k < 5; k++) run_period(1'b0);
    check("drained", int'(fifo_count), 0);

    // 4: underrun repeats the last sample; set beats clear
    push(8'h80);
    run_period(1'b0);
    run_period(1'b0);
    run_period(1'b1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    m_underrun = 1'b0;
    check("clr_alone", int'(underrun), 0);

    // 5: empty tick in IDLE has no effect, then a first sample
    @(negedge clk);
    apply_reset();
    run_period(1'b0);
    push(8'h20);
    run_period(1'b0);

    // 6: asynchronous reset mid-period while output is high
    push(8'hC0);
    push(8'h01);
    push(8'h02);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_pwm", int'(pwm_out), 1);
    check("pre_rst_count", int'(fifo_count), 2);
    #2 nrst = 1'b0;
    #1;
    check("async_pwm", int'(pwm_out), 0);
    check("async_count", int'(fifo_count), 0);
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    @(negedge clk);
    check("post_rst_count", int'(fifo_count), 0);
    run_period(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_pwm_dac.md
Name: sample_pwm_dac

Overview:
Consumer end of the sample-rate strobe produced by the sample-rate clock divider. Upstream sample generators push 8-bit unsigned samples into a small FIFO over a valid/ready handshake. On each sample_tick the block pops one sample into its duty register. It then outputs a 256-step PWM waveform aligned to the tick, which drives the external RC audio filter.

Parameters:
WIDTH, 8, sample and PWM counter width; the period is 2^WIDTH clk cycles, matching the divider's 256-cycle strobe.
DEPTH, 4, FIFO depth in samples; must be a power of 2 and at least 2.

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous reset, active-low
sample_tick  input  1  one-cycle strobe from the sample-rate divider
sample_in  input  WIDTH  unsigned sample data
sample_valid  input  1  upstream has a sample on sample_in
sample_ready  output  1  FIFO can accept a sample this cycle
underrun_clr  input  1  clears the sticky underrun flag
pwm_out  output  1  PWM audio output
underrun  output  1  sticky flag: a tick found the FIFO empty while in RUN
fifo_count  output  $clog2(DEPTH)+1  number of samples currently held

Behaviour:
- Reset (nrst low, asynchronous):
  - FIFO pointers and count = 0; duty = 0; pwm_cnt = 0.
  - state = IDLE; underrun = 0; pwm_out = 0 immediately.
  - sample_ready = 1 as soon as reset releases (count 0).
- Handshake:
  - sample_ready = (count < DEPTH), decoded from the registered count.
  - A push happens on a clk edge where sample_valid && sample_ready.
  - When full, ready stays 0 even if a pop occurs in the same cycle; the push is accepted the following cycle.
  - Upstream holds sample_in and sample_valid until accepted.
- Pop: occurs on an edge where sample_tick = 1 and count > 0.
  - The head sample loads into duty; the read pointer advances.
  - A push and a pop in the same cycle (count not full) both take effect; count is unchanged.
  - A push into an empty FIFO is not visible to a pop in the same cycle (no bypass).
- State machine:
  - IDLE: pwm_out forced 0. On a tick with count > 0: pop, go to RUN. On a tick with count == 0: no effect, no underrun.
  - RUN, tick with count > 0: pop and reload duty.
  - RUN, tick with count == 0: duty holds its previous value (last sample repeats) and underrun sets to 1.
  - RUN never returns to IDLE except through reset.
- PWM counter pwm_cnt (WIDTH bits):
  - On any tick edge, pwm_cnt loads 0. This realigns the period even if the tick arrives early or late.
  - Otherwise pwm_cnt increments, wrapping from 2^WIDTH-1 to 0.
  - It runs in IDLE too.
- Output:
  - pwm_out = (state == RUN) && (pwm_cnt < duty), decoded from registered state, counter and duty; no combinational path from inputs.
  - The first high cycle is the cycle after the tick edge (pwm_cnt = 0, new duty).
  - duty 0 gives constant low; duty 255 gives 255 of 256 cycles high.
- underrun:
  - Sets on an underrun tick; clears on the edge where underrun_clr = 1.
  - If set and clear occur in the same cycle, set wins.
- Comparison is unsigned and full-width; there is no sign handling.

Test Plan:
1. Reset: hold nrst low, drive ticks and valid -> pwm_out=0, underrun=0, fifo_count=0. Release -> sample_ready=1.
2. Push 0x40, 0x80, 0xFF, then tick every 256 clk -> pwm_out high for exactly 64, 128 and 255 cycles in successive periods; each high run starts the cycle after the tick; fifo_count goes 3→2→1→0.
3. Hold sample_valid with data 0x10..0x14 -> four samples accepted, fifo_count=4, sample_ready=0. The fifth sample (0x14) is accepted on the cycle after the next tick's pop. Playback order is 0x10, 0x11, 0x12, 0x13, 0x14.
4. In RUN, play 0x80 then tick with FIFO empty -> underrun=1, pwm_out repeats 128-high periods. Assert underrun_clr together with another underrun tick -> underrun stays 1. Assert underrun_clr alone -> underrun=0.
5. After reset, tick with FIFO empty -> state stays IDLE, underrun=0, pwm_out=0. Push 0x20, then tick -> 32-cycle high pulse.
6. Assert nrst low mid-period with pwm_out=1 and FIFO at 2 -> pwm_out=0 with no clk edge needed. After release: fifo_count=0, state IDLE.
